// File: rtl/pr_seq_pkg.sv
// Shared definitions for the two-region PR sequencer.
//   - seq_state_t : sequencer FSM states
//   - STATUS_*    : result codes reported on o_status with each ack
//   - inResetPhase: states in which the granted region's reset_n is asserted
package pr_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FREEZE,
    S_RESET_HOLD,
    S_PR_START,
    S_PR_WAIT,
    S_UNFREEZE,
    S_RELEASE,
    S_ERROR
  } seq_state_t;

  localparam logic [2:0] STATUS_OK               = 3'd0;
  localparam logic [2:0] STATUS_FREEZE_TIMEOUT   = 3'd1;
  localparam logic [2:0] STATUS_PR_ERROR         = 3'd2;
  localparam logic [2:0] STATUS_UNFREEZE_TIMEOUT = 3'd3;
  localparam logic [2:0] STATUS_ILLEGAL_REQ      = 3'd4;

  // The region is held in reset from the hold phase until it is released.
  function automatic logic inResetPhase(input seq_state_t s);
    return (s == S_RESET_HOLD) || (s == S_PR_START) ||
           (s == S_PR_WAIT) || (s == S_UNFREEZE);
  endfunction

endpackage

// File: rtl/pr_rr_arbiter2.sv
// Two-way round-robin arbiter with a last-served pointer.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_req[1:0]     : request per region
//   i_take         : the grant is consumed this cycle; pointer moves to it
//   o_valid        : at least one request is pending
//   o_grant        : region index being granted
module pr_rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic       o_valid,
  output logic       o_grant
);

  logic r_last;

  // With both regions requesting, grant the one not served last.
  always_comb begin
    o_valid = |i_req;
    if (&i_req) begin
      o_grant = ~r_last;
    end else begin
      o_grant = i_req[1];
    end
  end

  // Reset value 1 makes region 0 the favoured one after reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last <= 1'b1;
    end else if (i_take && o_valid) begin
      r_last <= o_grant;
    end
  end

endmodule

// File: rtl/pr_region_sequencer_2port.sv
// Sequencer for two PR regions behind freeze controllers. Grants one region
// at a time and runs freeze -> reset hold -> PR start/wait -> unfreeze ->
// reset release, then pulses ack with a status code.
// Ports:
//   i_clk, i_reset         : clock, synchronous active-high reset
//   i_req[1:0], o_ack[1:0] : per-region level request / completion pulse
//   o_status[2:0]          : result of the last sequence
//   o_busy                 : sequence in progress
//   o_active_region        : currently granted region
//   o_pr_start, i_pr_done, i_pr_error : PR engine handshake
//   o_freeze_req_n, o_unfreeze_req_n, o_reset_n        : controller n controls
//   i_freeze_status_n, i_unfreeze_status_n, i_illegal_req_n : controller n status
module pr_region_sequencer_2port
  import pr_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES    = 65535,
  parameter int RESET_HOLD_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_ack,
  output logic [2:0] o_status,
  output logic       o_busy,
  output logic       o_active_region,
  output logic       o_pr_start,
  input  logic       i_pr_done,
  input  logic       i_pr_error,
  output logic       o_freeze_req_0,
  output logic       o_unfreeze_req_0,
  output logic       o_reset_0,
  input  logic       i_freeze_status_0,
  input  logic       i_unfreeze_status_0,
  input  logic [1:0] i_illegal_req_0,
  output logic       o_freeze_req_1,
  output logic       o_unfreeze_req_1,
  output logic       o_reset_1,
  input  logic       i_freeze_status_1,
  input  logic       i_unfreeze_status_1,
  input  logic [1:0] i_illegal_req_1
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] HOLD_LAST   = 16'(RESET_HOLD_CYCLES - 1);

  seq_state_t  r_state, w_stateNext;
  logic [2:0]  r_status, w_statusNext;
  logic [15:0] r_cnt;
  logic        r_active;
  logic [1:0]  r_stuck;
  logic        w_grantValid, w_grant, w_grantTake;
  logic        w_cntClear, w_stuckSet, w_stuckClear;
  logic        w_inSeq, w_illegal, w_frzSts, w_unfSts, w_timeoutHit;

  pr_rr_arbiter2 u_arb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   (i_req),
    .i_take  (w_grantTake),
    .o_valid (w_grantValid),
    .o_grant (w_grant)
  );

  assign w_inSeq   = (r_state != S_IDLE) && (r_state != S_RELEASE) && (r_state != S_ERROR);
  assign w_illegal = r_active ? (i_illegal_req_1 != 2'b00) : (i_illegal_req_0 != 2'b00);
  assign w_frzSts  = r_active ? i_freeze_status_1 : i_freeze_status_0;
  assign w_unfSts  = r_active ? i_unfreeze_status_1 : i_unfreeze_status_0;
  // A limit of zero disables the freeze/unfreeze timeout.
  assign w_timeoutHit = (TIMEOUT_LIM != 16'd0) && ((r_cnt + 16'd1) == TIMEOUT_LIM);

  // Next-state logic; an illegal request overrides whatever the state chose.
  always_comb begin
    w_stateNext  = r_state;
    w_statusNext = r_status;
    w_grantTake  = 1'b0;
    w_cntClear   = 1'b0;
    w_stuckSet   = 1'b0;
    w_stuckClear = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grantValid) begin
          w_grantTake = 1'b1;
          w_cntClear  = 1'b1;
          w_stateNext = S_FREEZE;
        end
      end
      S_FREEZE: begin
        if (w_frzSts) begin
          w_cntClear  = 1'b1;
          w_stateNext = S_RESET_HOLD;
        end else if (w_timeoutHit) begin
          w_stateNext  = S_ERROR;
          w_statusNext = STATUS_FREEZE_TIMEOUT;
        end
      end
      S_RESET_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_stateNext = S_PR_START;
        end
      end
      S_PR_START: w_stateNext = S_PR_WAIT;
      S_PR_WAIT: begin
        if (i_pr_error) begin
          w_stateNext  = S_ERROR;
          w_statusNext = STATUS_PR_ERROR;
          w_stuckSet   = 1'b1;
        end else if (i_pr_done) begin
          w_cntClear  = 1'b1;
          w_stateNext = S_UNFREEZE;
        end
      end
      S_UNFREEZE: begin
        if (w_unfSts) begin
          w_stateNext  = S_RELEASE;
          w_statusNext = STATUS_OK;
          w_stuckClear = 1'b1;
        end else if (w_timeoutHit) begin
          w_stateNext  = S_ERROR;
          w_statusNext = STATUS_UNFREEZE_TIMEOUT;
          w_stuckSet   = 1'b1;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
    if (w_inSeq && w_illegal) begin
      w_stateNext  = S_ERROR;
      w_statusNext = STATUS_ILLEGAL_REQ;
      w_stuckSet   = inResetPhase(r_state);
      w_stuckClear = 1'b0;
    end
  end

  // State, status, grant and the shared wait/hold counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_status <= STATUS_OK;
      r_active <= 1'b0;
      r_cnt    <= 16'd0;
    end else begin
      r_state  <= w_stateNext;
      r_status <= w_statusNext;
      if (w_grantTake) begin
        r_active <= w_grant;
      end
      if (w_cntClear) begin
        r_cnt <= 16'd0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // A region that failed while in reset stays in reset until a later success.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stuck <= 2'b00;
    end else if (w_stuckSet) begin
      r_stuck[r_active] <= 1'b1;
    end else if (w_stuckClear) begin
      r_stuck[r_active] <= 1'b0;
    end
  end

  // Per-region output muxing; only the granted region sees freeze/unfreeze.
  always_comb begin
    o_busy           = w_inSeq;
    o_status         = r_status;
    o_active_region  = r_active;
    o_pr_start       = (r_state == S_PR_START);
    o_ack            = 2'b00;
    if ((r_state == S_RELEASE) || (r_state == S_ERROR)) begin
      o_ack = r_active ? 2'b10 : 2'b01;
    end
    o_freeze_req_0   = (r_state == S_FREEZE) && !r_active;
    o_freeze_req_1   = (r_state == S_FREEZE) && r_active;
    o_unfreeze_req_0 = (r_state == S_UNFREEZE) && !r_active;
    o_unfreeze_req_1 = (r_state == S_UNFREEZE) && r_active;
    o_reset_0        = (inResetPhase(r_state) && !r_active) || r_stuck[0];
    o_reset_1        = (inResetPhase(r_state) && r_active) || r_stuck[1];
  end

endmodule

// File: tb/tb_pr_region_sequencer_2port.sv
// Self-checking bench for pr_region_sequencer_2port. Behavioural freeze
// controllers and PR engine respond to the DUT; expected acks are queued
// when requests are driven and popped when the DUT pulses ack.
module tb_pr_region_sequencer_2port;
  import pr_seq_pkg::*;

  typedef struct {
    logic       region;
    logic [2:0] status;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [1:0] i_req = 2'b00;
  logic [1:0] o_ack;
  logic [2:0] o_status;
  logic       o_busy, o_active_region, o_pr_start;
  logic       i_pr_done = 1'b0, i_pr_error = 1'b0;
  logic       o_freeze_req_0, o_unfreeze_req_0, o_reset_0;
  logic       i_freeze_status_0 = 1'b0, i_unfreeze_status_0 = 1'b0;
  logic [1:0] i_illegal_req_0 = 2'b00;
  logic       o_freeze_req_1, o_unfreeze_req_1, o_reset_1;
  logic       i_freeze_status_1 = 1'b0, i_unfreeze_status_1 = 1'b0;
  logic [1:0] i_illegal_req_1 = 2'b00;

  int   cmpCount = 0;
  int   errCount = 0;
  exp_t sbQ[$];

  // Model configuration, written only by the main stimulus process.
  int   frzDly = 3, unfDly = 2, prDly = 10;
  logic frzNever1 = 1'b0;
  logic prErrBoth = 1'b0;

  // Monitor observations.
  int prStartCount = 0, r1Count = 0, holdRunAtStart = 0, frzRun1AtAck = 0;
  int rst0Run = 0, frzRun1 = 0;

  pr_region_sequencer_2port #(
    .TIMEOUT_CYCLES    (8),
    .RESET_HOLD_CYCLES (16)
  ) dut (
    .i_clk               (clk),
    .i_reset             (i_reset),
    .i_req               (i_req),
    .o_ack               (o_ack),
    .o_status            (o_status),
    .o_busy              (o_busy),
    .o_active_region     (o_active_region),
    .o_pr_start          (o_pr_start),
    .i_pr_done           (i_pr_done),
    .i_pr_error          (i_pr_error),
    .o_freeze_req_0      (o_freeze_req_0),
    .o_unfreeze_req_0    (o_unfreeze_req_0),
    .o_reset_0           (o_reset_0),
    .i_freeze_status_0   (i_freeze_status_0),
    .i_unfreeze_status_0 (i_unfreeze_status_0),
    .i_illegal_req_0     (i_illegal_req_0),
    .o_freeze_req_1      (o_freeze_req_1),
    .o_unfreeze_req_1    (o_unfreeze_req_1),
    .o_reset_1           (o_reset_1),
    .i_freeze_status_1   (i_freeze_status_1),
    .i_unfreeze_status_1 (i_unfreeze_status_1),
    .i_illegal_req_1     (i_illegal_req_1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmpCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] allOutputs();
    return {18'd0, o_ack, o_status, o_busy, o_active_region, o_pr_start,
            o_freeze_req_0, o_unfreeze_req_0, o_reset_0,
            o_freeze_req_1, o_unfreeze_req_1, o_reset_1};
  endfunction

  task automatic pushExpect(input logic region, input logic [2:0] status);
    exp_t e;
    e.region = region;
    e.status = status;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [1:0] req);
    @(negedge clk);
    i_req = req;
  endtask

  // Waits for an ack pulse; the acked request bit is dropped in the same cycle.
  task automatic waitAck(input int maxCycles, output int waited);
    logic seen;
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < maxCycles) begin
      @(negedge clk);
      waited++;
      if (o_ack != 2'b00) begin
        seen  = 1'b1;
        i_req = i_req & ~o_ack;
      end
    end
    checkOutput("ackArrived", 32'(seen), 32'd1);
  endtask

  // Freeze controllers and PR engine, reacting to the DUT at the falling edge.
  initial begin
    int frzCnt0 = 0, frzCnt1 = 0, unfCnt0 = 0, unfCnt1 = 0, prCnt = 0;
    forever begin
      @(negedge clk);
      if (o_freeze_req_0) frzCnt0++; else frzCnt0 = 0;
      if (o_freeze_req_1) frzCnt1++; else frzCnt1 = 0;
      if (o_unfreeze_req_0) unfCnt0++; else unfCnt0 = 0;
      if (o_unfreeze_req_1) unfCnt1++; else unfCnt1 = 0;
      i_freeze_status_0   = (frzCnt0 >= frzDly);
      i_freeze_status_1   = !frzNever1 && (frzCnt1 >= frzDly);
      i_unfreeze_status_0 = (unfCnt0 >= unfDly);
      i_unfreeze_status_1 = (unfCnt1 >= unfDly);
      i_pr_done  = 1'b0;
      i_pr_error = 1'b0;
      if (i_reset) begin
        prCnt = 0;
      end else if (o_pr_start) begin
        prCnt = prDly;
      end else if (prCnt > 0) begin
        prCnt--;
        if (prCnt == 0) begin
          i_pr_done  = 1'b1;
          i_pr_error = prErrBoth;
        end
      end
    end
  end

  // Scoreboard consumer and run-length observers.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_ack != 2'b00) begin
        frzRun1AtAck = frzRun1;
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedAck", 32'(o_ack), 32'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("ackBits", 32'(o_ack), e.region ? 32'd2 : 32'd1);
          checkOutput("ackStatus", 32'(o_status), 32'(e.status));
          checkOutput("ackRegion", 32'(o_active_region), 32'(e.region));
          checkOutput("busyAtAck", 32'(o_busy), 32'd0);
        end
      end
      if (o_pr_start) begin
        prStartCount++;
        holdRunAtStart = rst0Run;
      end
      if (o_reset_0 && !o_pr_start) rst0Run++; else rst0Run = 0;
      if (o_freeze_req_1) frzRun1++; else frzRun1 = 0;
      if (o_freeze_req_1 || o_unfreeze_req_1 || o_reset_1) r1Count++;
    end
  end

  initial begin
    int w, r1Before, pStart;
    logic seen;

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", allOutputs(), 32'd0);
    i_reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idleOutputs", allOutputs(), 32'd0);

    $display("[TB] both regions requesting");
    pushExpect(1'b0, STATUS_OK);
    pushExpect(1'b1, STATUS_OK);
    applyStimulus(2'b11);
    waitAck(200, w);
    waitAck(200, w);
    @(negedge clk);
    checkOutput("statusHeldOk", 32'(o_status), 32'(STATUS_OK));

    $display("[TB] single sequence on region 0");
    r1Before = r1Count;
    pushExpect(1'b0, STATUS_OK);
    applyStimulus(2'b01);
    waitAck(200, w);
    @(negedge clk);
    checkOutput("holdCycles", 32'(holdRunAtStart), 32'd16);
    checkOutput("r1Quiet", 32'(r1Count - r1Before), 32'd0);
    checkOutput("rst0AfterOk", 32'(o_reset_0), 32'd0);

    $display("[TB] freeze timeout on region 1");
    frzNever1 = 1'b1;
    pushExpect(1'b1, STATUS_FREEZE_TIMEOUT);
    applyStimulus(2'b10);
    waitAck(200, w);
    @(negedge clk);
    checkOutput("frzWaitCycles", 32'(frzRun1AtAck), 32'd8);
    checkOutput("frz1Dropped", 32'(o_freeze_req_1), 32'd0);
    checkOutput("rst1Low", 32'(o_reset_1), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("statusHeldTo", 32'(o_status), 32'(STATUS_FREEZE_TIMEOUT));
    frzNever1 = 1'b0;

    $display("[TB] PR error with done on region 0");
    prErrBoth = 1'b1;
    pushExpect(1'b0, STATUS_PR_ERROR);
    applyStimulus(2'b01);
    waitAck(200, w);
    prErrBoth = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst0Stuck", 32'(o_reset_0), 32'd1);
    checkOutput("frz0Low", 32'(o_freeze_req_0), 32'd0);
    pushExpect(1'b0, STATUS_OK);
    applyStimulus(2'b01);
    waitAck(200, w);
    @(negedge clk);
    checkOutput("rst0Released", 32'(o_reset_0), 32'd0);

    $display("[TB] illegal request during reset hold");
    pStart = prStartCount;
    applyStimulus(2'b01);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = o_reset_0;
    end
    checkOutput("holdReached", 32'(seen), 32'd1);
    i_illegal_req_0 = 2'b10;
    pushExpect(1'b0, STATUS_ILLEGAL_REQ);
    waitAck(20, w);
    i_illegal_req_0 = 2'b00;
    checkOutput("illegalLatency", 32'(w), 32'd1);
    checkOutput("noPrStart", 32'(prStartCount - pStart), 32'd0);

    $display("[TB] reset during PR wait");
    applyStimulus(2'b01);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = o_pr_start;
    end
    checkOutput("prStartSeen", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("busyInWait", 32'(o_busy), 32'd1);
    i_reset = 1'b1;
    i_req   = 2'b00;
    @(negedge clk);
    checkOutput("midResetOutputs", allOutputs(), 32'd0);
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("afterResetOutputs", allOutputs(), 32'd0);
    checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/pr_region_sequencer_2port.md
Name: pr_region_sequencer_2port

Overview:
Hardware sequencer for two PR regions, each behind its own freeze controller (freeze/unfreeze/reset/illegal-request interface). It takes per-region reconfiguration requests and round-robin arbitrates between them. For the granted region it runs freeze -> reset hold -> PR engine start/wait -> unfreeze -> reset release, then reports status. It replaces host PIO bit-banging of the freeze controllers and sits between the host CSR block, the PR engine and the two controllers.

Parameters:
TIMEOUT_CYCLES, 65535, max cycles to wait for freeze_status/unfreeze_status (16-bit counter); 0 disables the timeout
RESET_HOLD_CYCLES, 16, cycles reset_n is held high before pr_start is issued (min 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  2  level request per region (bit n = region n); held until ack
ack  output  2  one-cycle pulse on bit n when region n's sequence completes (success or error)
status  output  3  result of the last sequence; valid from the ack cycle, held until the next ack
busy  output  1  sequence in progress
active_region  output  1  region currently granted; holds its value while idle
pr_start  output  1  one-cycle start pulse to the PR engine
pr_done  input  1  PR engine completion, sampled in PR_WAIT only
pr_error  input  1  PR engine failure, sampled in PR_WAIT only
freeze_req_0, unfreeze_req_0, reset_0  output  1 each  controller 0 controls
freeze_status_0, unfreeze_status_0  input  1 each  controller 0 status
illegal_req_0  input  2  controller 0 illegal-request flags
freeze_req_1, unfreeze_req_1, reset_1, freeze_status_1, unfreeze_status_1, illegal_req_1: same as region 0, for controller 1

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer favours region 0. Reset mid-sequence drops freeze_req/unfreeze_req/reset_n immediately; no unfreeze is issued.
- Status codes: 0 OK, 1 FREEZE_TIMEOUT, 2 PR_ERROR, 3 UNFREEZE_TIMEOUT, 4 ILLEGAL_REQ.
- IDLE:
  - Grants the requesting region. If both request, grants the one not last served.
  - Latches active_region, sets busy, then goes to FREEZE in the next cycle.
- FREEZE:
  - freeze_req_n held high until freeze_status_n is sampled high.
  - Then freeze_req_n drops and the FSM goes to RESET_HOLD.
  - If freeze_status_n is already high on entry, FREEZE lasts 1 cycle.
- RESET_HOLD: reset_n high for exactly RESET_HOLD_CYCLES cycles, then go to PR_START.
- PR_START: pr_start high for 1 cycle, then PR_WAIT.
- PR_WAIT:
  - No timeout.
  - pr_done -> UNFREEZE.
  - pr_error -> error 2. pr_error wins if both are asserted in the same cycle.
- UNFREEZE:
  - reset_n stays high.
  - unfreeze_req_n held high until unfreeze_status_n is sampled high.
  - Then go to RELEASE.
- RELEASE:
  - reset_n drops; ack[n] pulses with status 0; busy clears; back to IDLE.
  - A new grant is possible in the following cycle.
- Timeout:
  - A 16-bit counter clears on entry to FREEZE and to UNFREEZE.
  - When it reaches TIMEOUT_CYCLES without the expected status -> error 1 or 3.
- Illegal request: illegal_req_n != 0 for the active region in any state other than IDLE/RELEASE -> error 4, which takes priority over the other errors in the same cycle.
- Error exit (1 cycle):
  - Deassert freeze_req_n and unfreeze_req_n; keep reset_n high.
  - Pulse ack[n] with the error status, clear busy, return to IDLE.
  - The region stays frozen and in reset until a later successful sequence on that region.
- The inactive region's outputs are never driven, except its reset_n, which stays high if its last sequence failed.
- Dropping req[n] mid-sequence has no effect; the sequence completes.

Decomposition:
- Shared package pr_seq_pkg holds the state enum (IDLE, FREEZE, RESET_HOLD, PR_START, PR_WAIT, UNFREEZE, RELEASE, ERROR) and the status code constants.
- Sub-module pr_rr_arbiter2 holds the 2-way round-robin grant and last-served pointer.
- The FSM, counters and per-region output muxing stay in the top level.

Test Plan:
- req=01; freeze_status_0 rises 3 cycles after freeze_req_0; pr_done 10 cycles after pr_start; unfreeze_status_0 after 2 cycles -> reset_0 high for exactly 16 cycles before pr_start; ack=01 with status 0; region 1 outputs stay 0 throughout.
- req=11 held across two sequences -> region 0 served first, then region 1; ack pulses 01 then 10; active_region 0 then 1.
- TIMEOUT_CYCLES=8, freeze_status_1 never rises -> ack=10, status 1 at the 8th wait cycle; freeze_req_1 drops; reset_1 stays 0.
- pr_error and pr_done asserted together in PR_WAIT -> status 2; reset_n stays 1 after ack; a following successful sequence on that region releases it.
- illegal_req_0=2'b10 during RESET_HOLD -> status 4 on the next cycle; pr_start is never pulsed.
- reset asserted in PR_WAIT -> all outputs 0 on the next cycle; busy=0; no ack pulse.
